bcd_conv_scheduler: RTL and testbench
=====================================

Name: bcd_conv_scheduler

Overview:
- Shares one iterative (shift-and-add-3) binary-to-BCD converter between NUM_REQ requesters, e.g. switch banks feeding separate 7-segment display groups.
- Round-robin arbitration, request/grant capture, then DATA_W serial iterations. The result is returned with a per-requester done pulse and an owner index.
- Sits between input sources and the BCD_Display decoders. Replaces the single-cycle unrolled conversion with a timing-friendly multi-cycle one.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- DATA_W, 8, binary input width per requester
- BCD_DIGITS, 3, output digits; 10^BCD_DIGITS must exceed 2^DATA_W-1 (static check at elaboration)

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  request per requester, level
- REQ_DATA  in  NUM_REQ*DATA_W  binary value; slice i belongs to REQ[i]
- GNT  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data captured
- DONE  out  NUM_REQ  one-hot, one-cycle pulse: BCD_OUT valid for that requester
- BCD_OUT  out  4*BCD_DIGITS  packed BCD result; digit 0 in bits [3:0]
- BCD_OWNER  out  clog2(NUM_REQ)  index of the requester that owns BCD_OUT
- BUSY  out  1  high while a conversion is in progress

Behaviour:
- Reset: all outputs are 0. State is IDLE, the iteration counter is 0, and the round-robin pointer gives requester 0 the highest priority.
- FSM states: IDLE, SHIFT.
- IDLE with any REQ set:
  - At the edge, grant the first set REQ at or after the pointer (search order pointer, pointer+1, ... wrapping).
  - Capture that requester's REQ_DATA into the shift register and clear the BCD accumulator.
  - GNT[i]=1 for the next cycle only. Set BUSY=1 and go to SHIFT with the counter at 0.
- IDLE with no REQ: hold. GNT and DONE stay 0.
- SHIFT, one iteration per cycle:
  - Each BCD digit >= 5 gets +3 (4-bit result).
  - Then {bcd, shreg} shifts left by 1, with the MSB of shreg entering bcd bit 0.
  - The counter increments.
- After the iteration with counter == DATA_W-1, at the same edge:
  - BCD_OUT <= final accumulator; BCD_OWNER <= i; DONE[i]=1 for one cycle.
  - BUSY=0; the pointer moves to i+1 (mod NUM_REQ); return to IDLE.
- Latency: the GNT pulse and DONE pulse are exactly DATA_W cycles apart (8 for defaults).
- Throughput: one conversion per DATA_W+1 cycles. A new grant can issue on the edge after DONE.
- BCD_OUT and BCD_OWNER hold their last values until the next DONE. They never show partial accumulator values.
- REQ and REQ_DATA are sampled only in IDLE. A requester must hold both until it sees GNT.
  - Dropping REQ before the grant withdraws the request silently.
  - REQ and REQ_DATA changes during SHIFT have no effect on the running conversion.
- REQ[i] still high in the cycle after DONE[i] is treated as a new request.
- RESET mid-conversion:
  - The conversion aborts; no DONE is issued.
  - All outputs clear at that edge; the pointer returns to 0.
- Arithmetic: an unsigned input of 0 converts to all-zero BCD. The maximum 2^DATA_W-1 must not overflow BCD_DIGITS. Add-3 never carries across digits.

Decomposition:
- Package bcd_sched_pkg holds:
  - state enum {IDLE, SHIFT}
  - ADD3_THRESH = 4'd5
  - default DATA_W and BCD_DIGITS constants
  - a function returning the counter width clog2(DATA_W)
- Sub-module bcd_dabble_step (combinational): per-digit add-3 followed by a 1-bit shift-in. Inputs: bcd vector and serial bit. Output: next bcd vector. It is instantiated once, inside SHIFT.
- The arbiter and FSM stay in bcd_conv_scheduler.

Test Plan:
- Reset, then REQ=01 with data0=255 -> GNT=01 for 1 cycle; DONE=01 exactly 8 cycles later; BCD_OUT=12'h255, BCD_OWNER=0, BUSY high for 8 cycles.
- Single requester, data 0, 9, 100, 128 in turn -> BCD_OUT=12'h000, 12'h009, 12'h100, 12'h128. Each DONE comes 8 cycles after its GNT; grants are spaced at least 9 cycles apart.
- Both REQ held, data0=12, data1=200 -> grant order 0,1,0,1. DONE results alternate 12'h012 (owner 0) and 12'h200 (owner 1). There are no idle cycles between DONE and the next GNT.
- RESET for one cycle 4 cycles into a conversion -> no DONE; all outputs 0 next cycle. After release with both REQ high, requester 0 is granted first.
- REQ1 raised and dropped while BUSY, before any grant -> GNT[1] never asserts; the requester 0 conversion completes unaffected. Changing REQ_DATA[0] after GNT does not alter the result.
- Exhaustive sweep of 0..255 on every port with random REQ patterns -> every DONE's BCD_OUT matches a reference model; DONE and GNT are one-hot and each grant is matched by exactly one DONE.

Source files
------------

// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the time-multiplexed binary-to-BCD converter.
package bcd_sched_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [3:0] ADD3_THRESH    = 4'd5;
  localparam int         DEF_DATA_W     = 8;
  localparam int         DEF_BCD_DIGITS = 3;

  // Counter must hold 0..DATA_W-1.
  function automatic int cnt_width(input int data_w);
    return (data_w <= 2) ? 1 : $clog2(data_w);
  endfunction

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one binary bit.
module bcd_dabble_step
  import bcd_sched_pkg::*;
#(
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic [4*BCD_DIGITS-1:0] i_bcd,
  input  logic                    i_bit,
  output logic [4*BCD_DIGITS-1:0] o_bcd
);

  logic [4*BCD_DIGITS-1:0] w_adj;

  // Each digit is corrected independently; the 4-bit sum cannot carry out.
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
    assign w_adj[4*d +: 4] = (i_bcd[4*d +: 4] >= ADD3_THRESH) ? i_bcd[4*d +: 4] + 4'd3
                                                              : i_bcd[4*d +: 4];
  end

  assign o_bcd = {w_adj[4*BCD_DIGITS-2:0], i_bit};

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin shares one serial double-dabble converter between NUM_REQ requesters.
module bcd_conv_scheduler
  import bcd_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 2,
  parameter  int DATA_W     = DEF_DATA_W,
  parameter  int BCD_DIGITS = DEF_BCD_DIGITS,
  localparam int OWN_W      = $clog2(NUM_REQ)
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        DONE,
  output logic [4*BCD_DIGITS-1:0]   BCD_OUT,
  output logic [OWN_W-1:0]          BCD_OWNER,
  output logic                      BUSY
);

  localparam int CNT_W = cnt_width(DATA_W);

  if (pow10(BCD_DIGITS) <= (longint'(1) << DATA_W) - 1) begin : g_bad_digits
    $error("BCD_DIGITS too small to hold 2^DATA_W-1");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_req
    $error("NUM_REQ must be 2..4");
  end

  state_t                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [OWN_W-1:0]                r_ptr;
  logic [OWN_W-1:0]                r_cur;
  logic [DATA_W-1:0]               r_shreg;
  logic [4*BCD_DIGITS-1:0]         r_acc;
  logic [NUM_REQ-1:0]              r_gnt;
  logic [NUM_REQ-1:0]              r_done;
  logic [4*BCD_DIGITS-1:0]         r_bcd_out;
  logic [OWN_W-1:0]                r_owner;
  logic                            r_busy;

  logic [NUM_REQ-1:0][DATA_W-1:0] w_data;
  logic [2*NUM_REQ-1:0]           w_req2;
  logic                           w_pick_vld;
  logic [OWN_W-1:0]               w_off;
  logic [OWN_W:0]                 w_sum;
  logic [OWN_W-1:0]               w_pick_idx;
  logic [NUM_REQ-1:0]             w_pick_oh;
  logic [NUM_REQ-1:0]             w_cur_oh;
  logic [4*BCD_DIGITS-1:0]        w_acc_nxt;

  assign w_data = REQ_DATA;

  // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner.
  assign w_req2 = {REQ, REQ} >> r_ptr;

  always_comb begin
    w_pick_vld = |REQ;
    w_off      = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (w_req2[k]) w_off = OWN_W'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (OWN_W+1)'(NUM_REQ)) w_sum = w_sum - (OWN_W+1)'(NUM_REQ);
  end

  assign w_pick_idx = w_sum[OWN_W-1:0];
  assign w_pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
  assign w_cur_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_cur;

  bcd_dabble_step #(.BCD_DIGITS(BCD_DIGITS)) u_step (
    .i_bcd (r_acc),
    .i_bit (r_shreg[DATA_W-1]),
    .o_bcd (w_acc_nxt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_cur     <= '0;
      r_shreg   <= '0;
      r_acc     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_bcd_out <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_shreg <= w_data[w_pick_idx];
            r_acc   <= '0;
            r_cur   <= w_pick_idx;
            r_gnt   <= w_pick_oh;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_acc_nxt;
          r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
          r_cnt   <= r_cnt + 1'b1;
          // Last iteration publishes the freshly computed accumulator directly.
          if (r_cnt == CNT_W'(DATA_W-1)) begin
            r_bcd_out <= w_acc_nxt;
            r_owner   <= r_cur;
            r_done    <= w_cur_oh;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_ptr     <= (r_cur == OWN_W'(NUM_REQ-1)) ? '0 : r_cur + 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign DONE      = r_done;
  assign BCD_OUT   = r_bcd_out;
  assign BCD_OWNER = r_owner;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Bench for bcd_conv_scheduler: transaction-level model checked every cycle plus directed literal checks.
module tb_bcd_conv_scheduler;

  localparam int N = 2;
  localparam int W = 8;
  localparam int D = 3;

  logic             CLOCK_50 = 1'b0;
  logic             RESET    = 1'b1;
  logic [N-1:0]     REQ      = '0;
  logic [N*W-1:0]   REQ_DATA = '0;
  logic [N-1:0]     GNT, DONE;
  logic [4*D-1:0]   BCD_OUT;
  logic [0:0]       BCD_OWNER;
  logic             BUSY;

  bcd_conv_scheduler #(.NUM_REQ(N), .DATA_W(W), .BCD_DIGITS(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_DATA  (REQ_DATA),
    .GNT       (GNT),
    .DONE      (DONE),
    .BCD_OUT   (BCD_OUT),
    .BCD_OWNER (BCD_OWNER),
    .BUSY      (BUSY)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal digits via plain division.
  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Transaction model: a grant starts a job that completes W edges later.
  logic [N-1:0]   exp_gnt   = '0;
  logic [N-1:0]   exp_done  = '0;
  logic [4*D-1:0] exp_bcd   = '0;
  int             exp_owner = 0;
  logic           exp_busy  = 1'b0;
  int             m_ptr = 0, m_rem = 0, m_own = 0, m_val = 0, m_j = 0;

  initial forever begin
    @(posedge CLOCK_50);
    cyc++;
    exp_gnt  = '0;
    exp_done = '0;
    if (RESET) begin
      exp_bcd   = '0;
      exp_owner = 0;
      exp_busy  = 1'b0;
      m_ptr     = 0;
    end else if (!exp_busy) begin
      for (int k = 0; k < N; k++) begin
        m_j = (m_ptr + k) % N;
        if (REQ[m_j] && !exp_busy) begin
          exp_busy       = 1'b1;
          m_own          = m_j;
          m_val          = int'(REQ_DATA[m_j*W +: W]);
          m_rem          = W;
          exp_gnt[m_j]   = 1'b1;
        end
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        exp_done[m_own] = 1'b1;
        exp_bcd         = to_bcd(m_val);
        exp_owner       = m_own;
        exp_busy        = 1'b0;
        m_ptr           = (m_own + 1) % N;
      end
    end
  end

  always @(negedge CLOCK_50) begin
    chk("m_gnt",   GNT,       exp_gnt);
    chk("m_done",  DONE,      exp_done);
    chk("m_busy",  BUSY,      exp_busy);
    chk("m_bcd",   BCD_OUT,   exp_bcd);
    chk("m_owner", BCD_OWNER, exp_owner);
  end

  task automatic wait_gnt(input int i, output int at);
    at = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK_50);
      if (GNT[i]) begin at = cyc; break; end
    end
    chk("gnt_timeout", at >= 0, 1);
  endtask

  task automatic wait_done(input int i, output int at, output int nbusy, output int ngnt);
    at = -1; nbusy = 0; ngnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLOCK_50);
      if (BUSY) nbusy++;
      if (GNT != '0) ngnt++;
      if (DONE[i]) begin at = cyc; break; end
    end
    chk("done_timeout", at >= 0, 1);
  endtask

  int last_g = -1;

  task automatic single(input int i, input int v, input logic [11:0] lit, input string nm);
    int tg, td, nb, ng;
    REQ_DATA[i*W +: W] = W'(v);
    REQ[i] = 1'b1;
    wait_gnt(i, tg);
    REQ[i] = 1'b0;
    wait_done(i, td, nb, ng);
    chk({nm, "_lat"},  td - tg, 8);
    chk({nm, "_busy"}, nb + 1, 8);
    chk({nm, "_bcd"},  BCD_OUT, lit);
    chk({nm, "_own"},  BCD_OWNER, i);
    if (last_g >= 0) chk({nm, "_gap"}, (tg - last_g) >= 9, 1);
    last_g = tg;
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    @(negedge CLOCK_50);
    RESET = 1'b0;
  endtask

  initial begin
    int tg, td, nb, ng, gcount, dcount, limit;
    int sent [N];
    int v;

    repeat (3) @(negedge CLOCK_50);
    chk("rst_gnt",  GNT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_bcd",  BCD_OUT, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;

    single(0, 255, 12'h255, "max");
    single(0, 0,   12'h000, "zero");
    single(0, 9,   12'h009, "nine");
    single(0, 100, 12'h100, "hundred");
    single(0, 128, 12'h128, "d128");

    // Both requesters held: strict alternation with back-to-back grants.
    pulse_reset();
    REQ_DATA = {8'd200, 8'd12};
    REQ      = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_done(k % 2, td, nb, ng);
      chk("rr_owner", BCD_OWNER, k % 2);
      chk("rr_bcd",   BCD_OUT, (k % 2 == 0) ? 12'h012 : 12'h200);
      if (k < 3) begin
        @(negedge CLOCK_50);
        chk("rr_no_idle", GNT, (k % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    REQ = 2'b00;

    // Reset four cycles into a conversion.
    REQ_DATA[0 +: W] = 8'd55;
    REQ[0] = 1'b1;
    wait_gnt(0, tg);
    REQ[0] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b1;
    REQ   = 2'b11;
    REQ_DATA[0 +: W] = 8'd37;
    @(negedge CLOCK_50);
    chk("mid_rst_done",  DONE, 0);
    chk("mid_rst_bcd",   BCD_OUT, 0);
    chk("mid_rst_owner", BCD_OWNER, 0);
    chk("mid_rst_busy",  BUSY, 0);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    chk("post_rst_gnt", GNT, 2'b01);
    REQ = 2'b00;
    wait_done(0, td, nb, ng);
    chk("post_rst_bcd", BCD_OUT, 12'h037);

    // Transient REQ1 and REQ_DATA0 change while busy.
    REQ_DATA[0 +: W] = 8'd42;
    REQ[0] = 1'b1;
    wait_gnt(0, tg);
    REQ[0] = 1'b0;
    REQ[1] = 1'b1;
    REQ_DATA[0 +: W] = 8'd99;
    repeat (2) @(negedge CLOCK_50);
    REQ[1] = 1'b0;
    wait_done(0, td, nb, ng);
    chk("withdraw_no_gnt", ng, 0);
    chk("withdraw_bcd",    BCD_OUT, 12'h042);
    repeat (3) @(negedge CLOCK_50);
    chk("withdraw_idle_gnt", GNT, 0);

    // Random sweep: every value 0..255 on every port, random request timing.
    gcount = 0; dcount = 0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    limit = cyc + 30000;
    while ((sent[0] < 256 || sent[1] < 256 || REQ != '0 || BUSY) && cyc < limit) begin
      @(negedge CLOCK_50);
      for (int i = 0; i < N; i++) begin
        if (GNT[i]) begin sent[i]++; REQ[i] = 1'b0; gcount++; end
        if (DONE[i]) dcount++;
      end
      for (int i = 0; i < N; i++) begin
        if (!REQ[i] && sent[i] < 256 && $urandom_range(3) == 0) begin
          v = (sent[i] * 37 + i * 101) % 256;
          REQ_DATA[i*W +: W] = W'(v);
          REQ[i] = 1'b1;
        end else if (REQ[i] && $urandom_range(15) == 0) begin
          REQ[i] = 1'b0;
        end
      end
    end
    chk("sweep_timeout", cyc < limit, 1);
    chk("sweep_gnts",    gcount, 2 * 256);
    chk("sweep_dones",   dcount, gcount);

    repeat (2) @(negedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
